wave_capture: RTL and testbench
===============================

# wave_capture

Capture stage feeding the waveform display. It watches the audio sample stream and arms on a positive-going zero crossing. It then writes 256 consecutive samples, converted to 8-bit unsigned, into the half of the dual-port wave RAM that the display is not reading. Once the display reports idle (vertical blanking), it flips `read_index` so the display reads the new capture and the next capture goes to the other half.

## Interface
Parameters:
- `SAMPLE_WIDTH`, 16: width of the signed two's-complement input sample.
- `ADDR_WIDTH`, 9: RAM address width. MSB selects the buffer half; the low `ADDR_WIDTH-1` bits give the offset, so each half holds 256 entries.

Ports:
- `clk`  input  1: the single clock; all state updates on its rising edge.
- `reset`  input  1: asynchronous, active-high reset.
- `new_sample_ready`  input  1: one-cycle strobe; `new_sample_in` is valid in that cycle. Strobes may arrive on back-to-back cycles.
- `new_sample_in`  input  SAMPLE_WIDTH: signed audio sample.
- `wave_display_idle`  input  1: high while the display is not scanning the waveform region, so a buffer flip is safe.
- `write_address`  output  ADDR_WIDTH: RAM write address, `{~read_index, offset[7:0]}`.
- `write_enable`  output  1: one-cycle RAM write strobe.
- `write_sample`  output  8: unsigned sample, `{~new_sample_in[15], new_sample_in[14:8]}`.
- `read_index`  output  1: buffer half the display reads.
- `capture_state`  output  2: current FSM state (ARMED=0, ACTIVE=1, WAIT=2).

## Operation
- Registers:
  - `state` (2b)
  - `offset` (8b)
  - `prev_neg` (1b): sign bit of the last accepted sample
  - `read_index` (1b)
  - the registered write outputs
- `prev_neg <= new_sample_in[15]` on every `new_sample_ready`, in every state.
- A crossing occurs when `new_sample_ready`, `prev_neg == 1` and `new_sample_in[15] == 0`.
- ARMED:
  - A crossing writes the sample at offset 0, sets `offset <= 1` and moves to ACTIVE.
  - Samples that are not crossings are not written.
- ACTIVE:
  - Each `new_sample_ready` writes the sample at the current `offset`, then increments `offset`.
  - The write at offset 255 moves to WAIT, and `offset` wraps to 0.
  - Sign is not checked in ACTIVE.
- WAIT:
  - No writes.
  - When `wave_display_idle` is high: toggle `read_index`, set `offset <= 0`, move to ARMED.
  - A `new_sample_ready` arriving in the same cycle as the flip is not examined for a crossing; only `prev_neg` updates from it.
- Encoding 3 is illegal and recovers to ARMED on the next clock.
- `read_index` changes only on the WAIT->ARMED transition.
- During a capture, `write_address` MSB is always the complement of `read_index`. The displayed half is never written.

## Timing
- Reset values:
  - `state` = ARMED, `offset` = 0, `prev_neg` = 0, `read_index` = 0
  - `write_enable` = 0, `write_address` = 0, `write_sample` = 0, `capture_state` = 0
- Reset acts immediately and asynchronously, including in the middle of a capture. The partial capture is abandoned and `read_index` returns to 0.
- Write latency: a qualifying strobe in cycle N gives `write_enable` = 1 in cycle N+1, together with that sample's `write_address` and `write_sample`. `write_enable` is 0 in N+2 unless another strobe arrived in N+1.
- `write_address` and `write_sample` hold their last values while `write_enable` is 0.
- With back-to-back strobes, a capture completes in 256 consecutive write cycles.
- The final (offset 255) write appears in the cycle the FSM enters WAIT. The flip happens no earlier than the following cycle.
- `read_index` toggles in the cycle after the first WAIT cycle that samples `wave_display_idle` = 1.
- Because `prev_neg` resets to 0, the first sample after reset cannot be a crossing.

## Test plan
- Arming:
  - Stimulus: reset, then strobes 16'h0100, 16'h0200, 16'hFF00, 16'h0010.
  - Required: no write for the first three. The fourth gives `write_enable` = 1 next cycle with `write_address` = 9'h100, `write_sample` = 8'h80, and state becomes ACTIVE.
- Full capture:
  - Stimulus: after arming, 255 further back-to-back strobes with `new_sample_in` = {i[7:0], 8'h00}.
  - Required: writes cover addresses 9'h101..9'h1FF in order, with `write_sample` = i ^ 8'h80. State becomes WAIT after 9'h1FF, and no writes follow.
- Flip:
  - Stimulus: in WAIT, hold `wave_display_idle` = 0 for 10 cycles, then raise it.
  - Required: `read_index` stays 0, then becomes 1 one cycle after `wave_display_idle` rises; state returns to ARMED. The next capture uses addresses 9'h000..9'h0FF.
- Encoding:
  - Stimulus: crossing samples 16'h8000, 16'h7FFF, 16'h0000 written in ACTIVE.
  - Required: `write_sample` = 8'h00, 8'hFF, 8'h80 respectively.
- Flip collision:
  - Stimulus: in WAIT, a negative sample's strobe coincides with the idle flip, and the next strobe is 16'h0005.
  - Required: no write on the coinciding cycle. The 16'h0005 sample arms the capture (via `prev_neg` = 1) and is written at offset 0.
- Reset mid-capture:
  - Stimulus: assert `reset` after 100 writes in ACTIVE with `read_index` = 1.
  - Required: `write_enable`, `read_index` and `capture_state` are all 0 immediately, without waiting for a clock edge. No write occurs until a new crossing.

Source files
------------

// File: rtl/wave_capture.sv
// rtl/wave_capture.sv - zero-crossing triggered double-buffered waveform capture
module wave_capture #(
    parameter int SAMPLE_WIDTH = 16,
    parameter int ADDR_WIDTH   = 9
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    new_sample_ready,
    input  logic [SAMPLE_WIDTH-1:0] new_sample_in,
    input  logic                    wave_display_idle,
    output logic [ADDR_WIDTH-1:0]   write_address,
    output logic                    write_enable,
    output logic [7:0]              write_sample,
    output logic                    read_index,
    output logic [1:0]              capture_state
);

    localparam int OFFSET_WIDTH = ADDR_WIDTH - 1;

    typedef enum logic [1:0] {
        ST_ARMED  = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_WAIT   = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [OFFSET_WIDTH-1:0] offset;
    logic [OFFSET_WIDTH-1:0] offset_next;
    logic [OFFSET_WIDTH-1:0] write_offset;
    logic                    prev_neg;
    logic                    sample_neg;
    logic                    crossing;
    logic                    last_offset;
    logic                    do_write;
    logic                    flip;
    logic                    unused_low_bits;

    assign sample_neg      = new_sample_in[SAMPLE_WIDTH-1];
    assign crossing        = new_sample_ready && prev_neg && !sample_neg;
    assign last_offset     = (offset == {OFFSET_WIDTH{1'b1}});
    assign unused_low_bits = ^new_sample_in[SAMPLE_WIDTH-9:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_ARMED;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next  = state;
        offset_next = offset;
        case (state)
            ST_ARMED: begin
                if (crossing) begin
                    offset_next = OFFSET_WIDTH'(1);
                    state_next  = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (new_sample_ready) begin
                    // Incrementing past the last entry wraps offset back to 0.
                    offset_next = offset + 1'b1;
                    if (last_offset) begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wave_display_idle) begin
                    offset_next = '0;
                    state_next  = ST_ARMED;
                end
            end
            default: begin
                offset_next = '0;
                state_next  = ST_ARMED;
            end
        endcase
    end

    always_comb begin
        do_write      = 1'b0;
        write_offset  = offset;
        flip          = 1'b0;
        capture_state = state;
        case (state)
            ST_ARMED: begin
                do_write     = crossing;
                write_offset = '0;
            end
            ST_ACTIVE: begin
                do_write = new_sample_ready;
            end
            ST_WAIT: begin
                flip = wave_display_idle;
            end
            default: begin
                do_write = 1'b0;
            end
        endcase
    end

    // The write half is always the complement of the half being displayed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            offset        <= '0;
            prev_neg      <= 1'b0;
            read_index    <= 1'b0;
            write_enable  <= 1'b0;
            write_address <= '0;
            write_sample  <= '0;
        end else begin
            offset       <= offset_next;
            write_enable <= do_write;
            if (new_sample_ready) begin
                prev_neg <= sample_neg;
            end
            if (flip) begin
                read_index <= ~read_index;
            end
            if (do_write) begin
                write_address <= {~read_index, write_offset};
                write_sample  <= {~sample_neg, new_sample_in[SAMPLE_WIDTH-2 -: 7]};
            end
        end
    end

endmodule

// File: tb/tb_wave_capture.sv
// tb/tb_wave_capture.sv - scoreboard bench for wave_capture
module tb_wave_capture;

    logic        clk;
    logic        reset;
    logic        new_sample_ready;
    logic [15:0] new_sample_in;
    logic        wave_display_idle;
    logic [8:0]  write_address;
    logic        write_enable;
    logic [7:0]  write_sample;
    logic        read_index;
    logic [1:0]  capture_state;

    typedef struct packed {
        logic [8:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t        sb[$];
    wr_t        mon_e;
    int         vectors;
    int         miscompares;
    logic [8:0] last_addr;
    logic [7:0] last_data;
    logic [7:0] b;

    wave_capture #(
        .SAMPLE_WIDTH(16),
        .ADDR_WIDTH  (9)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .new_sample_ready (new_sample_ready),
        .new_sample_in    (new_sample_in),
        .wave_display_idle(wave_display_idle),
        .write_address    (write_address),
        .write_enable     (write_enable),
        .write_sample     (write_sample),
        .read_index       (read_index),
        .capture_state    (capture_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_write(input logic [8:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic send(input logic [15:0] s);
        new_sample_ready = 1'b1;
        new_sample_in    = s;
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            last_addr = '0;
            last_data = '0;
        end else if (write_enable) begin
            check("write_expected", 32'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_e = sb.pop_front();
                check("write_address", 32'(write_address), 32'(mon_e.addr));
                check("write_sample", 32'(write_sample), 32'(mon_e.data));
            end
            last_addr = write_address;
            last_data = write_sample;
        end else begin
            check("hold_address", 32'(write_address), 32'(last_addr));
            check("hold_sample", 32'(write_sample), 32'(last_data));
        end
    end

    initial begin
        vectors           = 0;
        miscompares       = 0;
        reset             = 1'b1;
        new_sample_ready  = 1'b0;
        new_sample_in     = '0;
        wave_display_idle = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_we", 32'(write_enable), 0);
        check("rst_addr", 32'(write_address), 0);
        check("rst_sample", 32'(write_sample), 0);
        check("rst_read_index", 32'(read_index), 0);
        check("rst_state", 32'(capture_state), 0);
        reset = 1'b0;

        // Arming: only a negative-to-positive transition triggers
        send(16'h0100);
        send(16'h0200);
        send(16'hFF00);
        check("arm_no_early_write", 32'(sb.size()), 0);
        expect_write(9'h100, 8'h80);
        send(16'h0010);
        check("arm_state", 32'(capture_state), 1);

        // Full capture into the upper half
        for (int i = 1; i < 256; i++) begin
            b = i[7:0];
            expect_write({1'b1, b}, b ^ 8'h80);
            send({b, 8'h00});
        end
        check("full_wait_state", 32'(capture_state), 2);

        // Held in WAIT while display busy; strobes must not write or arm
        for (int k = 0; k < 10; k++) begin
            new_sample_ready = k[0];
            new_sample_in    = 16'h1000;
            @(negedge clk);
            check("wait_read_index", 32'(read_index), 0);
            check("wait_state", 32'(capture_state), 2);
        end
        new_sample_ready  = 1'b0;
        wave_display_idle = 1'b1;
        @(negedge clk);
        wave_display_idle = 1'b0;
        check("flip_read_index", 32'(read_index), 1);
        check("flip_state", 32'(capture_state), 0);
        check("flip_sb_drained", 32'(sb.size()), 0);

        // Second capture into the lower half, interrupted by reset
        send(16'hF000);
        expect_write(9'h000, 8'h81);
        send(16'h0100);
        for (int i = 1; i < 100; i++) begin
            b = i[7:0];
            expect_write({1'b0, b}, {1'b1, b[6:0]});
            send({1'b0, b[6:0], 8'h00});
        end
        new_sample_ready = 1'b0;
        check("pre_reset_we", 32'(write_enable), 1);
        check("pre_reset_read_index", 32'(read_index), 1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_we", 32'(write_enable), 0);
        check("async_rst_read_index", 32'(read_index), 0);
        check("async_rst_state", 32'(capture_state), 0);
        @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);

        // First sample after reset cannot be a crossing
        send(16'h0100);
        send(16'h7000);
        new_sample_ready = 1'b0;
        @(negedge clk);
        check("post_reset_no_write", 32'(sb.size()), 0);
        check("post_reset_state", 32'(capture_state), 0);

        // Encoding extremes inside an active capture
        send(16'h8000);
        expect_write(9'h100, 8'h81);
        send(16'h0100);
        expect_write(9'h101, 8'h00);
        send(16'h8000);
        expect_write(9'h102, 8'hFF);
        send(16'h7FFF);
        expect_write(9'h103, 8'h80);
        send(16'h0000);
        for (int i = 4; i < 256; i++) begin
            b = i[7:0];
            expect_write({1'b1, b}, {1'b1, b[6:0]});
            send({1'b0, b[6:0], 8'h00});
        end
        new_sample_ready = 1'b0;
        check("enc_wait_state", 32'(capture_state), 2);
        check("enc_read_index", 32'(read_index), 0);

        // Negative strobe coincides with the flip, then a positive sample arms
        wave_display_idle = 1'b1;
        new_sample_ready  = 1'b1;
        new_sample_in     = 16'h8000;
        @(negedge clk);
        new_sample_ready  = 1'b0;
        wave_display_idle = 1'b0;
        check("coll_read_index", 32'(read_index), 1);
        check("coll_state", 32'(capture_state), 0);
        check("coll_no_write", 32'(write_enable), 0);
        expect_write(9'h000, 8'h80);
        send(16'h0005);
        new_sample_ready = 1'b0;
        check("coll_arm_state", 32'(capture_state), 1);
        @(negedge clk);
        check("final_sb_drained", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
